// File: rtl/tc_spi_scheduler_pkg.sv
// Shared types, timing constants and small helpers for the thermocouple
// SPI scheduler.
package tc_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        STARTUP   = 3'd0,
        SELECT    = 3'd1,
        REQUEST   = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } tc_state_e;

    // Nominal time base the constants below are expressed against.
    localparam int TC_NOM_CLK_FREQ = 1000;

    // Converter power-up settle time (3 s) and inter-sample gap (1 s).
    localparam int STARTUP_CYC = 3 * TC_NOM_CLK_FREQ;
    localparam int GAP_CYC     = TC_NOM_CLK_FREQ;

    // Rescale a nominal-time-base cycle count to an instance's clock rate.
    function automatic int f_scale_cyc(input int nom_cyc, input int clk_freq);
        return (nom_cyc / TC_NOM_CLK_FREQ) * clk_freq;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int f_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Larger of two integers.
    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tc_spi_scheduler_if.sv
// Bus bundle between the scheduler, the shared SPI master and the sample sink.
interface tc_spi_scheduler_if
    import tc_pkg::*;
#(
    parameter int NUM_CH = 4
) ();
    localparam int CH_W = f_ch_w(NUM_CH);

    logic [NUM_CH-1:0] ch_enable;
    logic              spi_not_busy;
    logic [31:0]       spi_rx_data;
    logic              spi_ena;
    logic [NUM_CH-1:0] spi_cs_n;
    logic              sample_valid;
    logic [CH_W-1:0]   sample_ch;
    logic [31:0]       sample_data;
    logic              sample_timeout;

    // Scheduler side: drives the SPI request, chip selects and samples.
    modport master (
        input  ch_enable,
        input  spi_not_busy,
        input  spi_rx_data,
        output spi_ena,
        output spi_cs_n,
        output sample_valid,
        output sample_ch,
        output sample_data,
        output sample_timeout
    );

    // Environment side: SPI master status, enables and sample consumer.
    modport slave (
        output ch_enable,
        output spi_not_busy,
        output spi_rx_data,
        input  spi_ena,
        input  spi_cs_n,
        input  sample_valid,
        input  sample_ch,
        input  sample_data,
        input  sample_timeout
    );

endinterface

// File: rtl/tc_spi_scheduler_rr_pick.sv
// Round-robin next-channel search: returns the first enabled channel
// strictly after 'last', wrapping from NUM_CH-1 back to 0.
module tc_rr_pick
    import tc_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = f_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   next,
    output logic              found
);

    int dist_s;
    int best_s;

    // Choose the enabled channel with the smallest wrap-around distance after 'last'.
    always_comb begin
        next   = {CH_W{1'b0}};
        best_s = NUM_CH;
        dist_s = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            // Distance 0 is the channel right after 'last'; 'last' itself is NUM_CH-1.
            dist_s = (j + 2 * NUM_CH - int'(last) - 1) % NUM_CH;
            if (ch_enable[j] && (dist_s < best_s)) begin
                best_s = dist_s;
                next   = CH_W'(j);
            end else begin
                best_s = best_s;
            end
        end
        found = (best_s < NUM_CH);
    end

endmodule

// File: rtl/tc_spi_scheduler.sv
// Thermocouple scan scheduler: after a power-up settle time it round-robins
// over the enabled converters, issues one SPI frame per selected channel,
// captures the result (or flags a timeout) and waits a fixed gap before
// selecting the next channel.
module tc_spi_scheduler
    import tc_pkg::*;
#(
    parameter int CLK_FREQ    = 1000,
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    tc_spi_scheduler_if.master bus
);

    localparam int CH_W      = f_ch_w(NUM_CH);
    localparam int STARTUP_N = f_scale_cyc(STARTUP_CYC, CLK_FREQ);
    localparam int GAP_N     = f_scale_cyc(GAP_CYC, CLK_FREQ);
    // One shared counter sized for the longest interval it has to measure.
    localparam int CNT_W     = $clog2(f_max(STARTUP_N, TIMEOUT_CYC) + 1);

    // Terminal counts: the counter runs 0..N-1, so N cycles elapse per interval.
    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_N - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_N - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    // Pointing "last served" at the top channel makes the first search start at ch0.
    localparam logic [CH_W-1:0]  LAST_RST     = CH_W'(NUM_CH - 1);

    tc_state_e         state_r,          state_s;
    logic [CNT_W-1:0]  cnt_r,            cnt_s;
    logic [CH_W-1:0]   last_r,           last_s;
    logic              spi_ena_r,        spi_ena_s;
    logic [NUM_CH-1:0] cs_n_r,           cs_n_s;
    logic              sample_valid_r,   sample_valid_s;
    logic [CH_W-1:0]   sample_ch_r,      sample_ch_s;
    logic [31:0]       sample_data_r,    sample_data_s;
    logic              sample_timeout_r, sample_timeout_s;

    logic [CH_W-1:0]   pick_next_s;
    logic              pick_found_s;

    tc_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .ch_enable (bus.ch_enable),
        .last      (last_r),
        .next      (pick_next_s),
        .found     (pick_found_s)
    );

    // Register state, counter and all outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= STARTUP;
            cnt_r            <= {CNT_W{1'b0}};
            last_r           <= LAST_RST;
            spi_ena_r        <= 1'b0;
            cs_n_r           <= {NUM_CH{1'b1}};
            sample_valid_r   <= 1'b0;
            sample_ch_r      <= {CH_W{1'b0}};
            sample_data_r    <= 32'h0000_0000;
            sample_timeout_r <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            last_r           <= last_s;
            spi_ena_r        <= spi_ena_s;
            cs_n_r           <= cs_n_s;
            sample_valid_r   <= sample_valid_s;
            sample_ch_r      <= sample_ch_s;
            sample_data_r    <= sample_data_s;
            sample_timeout_r <= sample_timeout_s;
        end
    end

    // Next-state and next-output logic; everything holds unless a state changes it.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        last_s           = last_r;
        spi_ena_s        = spi_ena_r;
        cs_n_s           = cs_n_r;
        sample_valid_s   = 1'b0;
        sample_ch_s      = sample_ch_r;
        sample_data_s    = sample_data_r;
        sample_timeout_s = sample_timeout_r;

        case (state_r)
            STARTUP: begin
                if (cnt_r == STARTUP_LAST) begin
                    state_s = SELECT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end

            SELECT: begin
                cnt_s = {CNT_W{1'b0}};
                if (pick_found_s) begin
                    // Chip select and start request go out together on entry to REQUEST.
                    state_s   = REQUEST;
                    last_s    = pick_next_s;
                    spi_ena_s = 1'b1;
                    for (int j = 0; j < NUM_CH; j++) begin
                        cs_n_s[j] = (CH_W'(j) != pick_next_s);
                    end
                end else begin
                    spi_ena_s = 1'b0;
                    cs_n_s    = {NUM_CH{1'b1}};
                end
            end

            REQUEST: begin
                // Keep asking until the master reports it has started the frame.
                if (bus.spi_not_busy) begin
                    spi_ena_s = 1'b1;
                end else begin
                    spi_ena_s = 1'b0;
                    state_s   = WAIT_DONE;
                    cnt_s     = {CNT_W{1'b0}};
                end
            end

            WAIT_DONE: begin
                if (bus.spi_not_busy) begin
                    // Frame finished: latch it against the channel that was selected.
                    state_s          = GAP;
                    cnt_s            = {CNT_W{1'b0}};
                    cs_n_s           = {NUM_CH{1'b1}};
                    sample_valid_s   = 1'b1;
                    sample_ch_s      = last_r;
                    sample_data_s    = bus.spi_rx_data;
                    sample_timeout_s = 1'b0;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    // Master never came back: report an empty sample and move on.
                    state_s          = GAP;
                    cnt_s            = {CNT_W{1'b0}};
                    cs_n_s           = {NUM_CH{1'b1}};
                    sample_valid_s   = 1'b1;
                    sample_ch_s      = last_r;
                    sample_data_s    = 32'h0000_0000;
                    sample_timeout_s = 1'b1;
                end else begin
                    cnt_s            = cnt_r + CNT_W'(1);
                end
            end

            GAP: begin
                cs_n_s = {NUM_CH{1'b1}};
                if (cnt_r == GAP_LAST) begin
                    state_s = SELECT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                // Unreachable encoding: fall back to the power-up sequence, bus idle.
                state_s   = STARTUP;
                cnt_s     = {CNT_W{1'b0}};
                spi_ena_s = 1'b0;
                cs_n_s    = {NUM_CH{1'b1}};
            end
        endcase
    end

    assign bus.spi_ena        = spi_ena_r;
    assign bus.spi_cs_n       = cs_n_r;
    assign bus.sample_valid   = sample_valid_r;
    assign bus.sample_ch      = sample_ch_r;
    assign bus.sample_data    = sample_data_r;
    assign bus.sample_timeout = sample_timeout_r;

endmodule
